// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg
// Shared definitions for the register-bus bridge:
//   - state_t     : bridge FSM encoding (IDLE / RD_WAIT)
//   - ERR_*       : values reported on oERR_CODE
//   - ERR_DATA_FILL : fill bit for the default ERR_DATA (all-ones at any width)
package reg_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PROTO   = 2'd3;

  // The default ERR_DATA is this bit replicated to DATA_WIDTH.
  localparam logic ERR_DATA_FILL = 1'b1;

endpackage

// File: rtl/reg_bus_timer.sv
// reg_bus_timer
// Loadable down-counter that bounds the read-wait of the bridge.
// Ports:
//   CLK      in   clock
//   RST      in   synchronous active-high reset (clears the count)
//   iLOAD    in   load the counter with TIMEOUT (wins over iEN)
//   iEN      in   count down one per cycle, saturating at 0
//   oEXPIRE  out  high in the last enabled cycle, i.e. the cycle the
//                 count steps from 1 to 0
module reg_bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic iLOAD,
  input  logic iEN,
  output logic oEXPIRE
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (iLOAD) begin
      count_next = LOAD_VAL;
    end else if (iEN && (count_reg != '0)) begin
      count_next = count_reg - ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Loaded with TIMEOUT on the request edge, the count is 1 in the
  // TIMEOUT-th wait cycle; flagging that cycle lets the bridge complete
  // exactly TIMEOUT+1 cycles after the request.
  assign oEXPIRE = iEN && !iLOAD && (count_reg == ONE);

endmodule

// File: rtl/reg_bus_bridge.sv
// reg_bus_bridge
// Host-to-register-module bridge with one transaction in flight.
// Writes complete from IDLE in one cycle; reads strobe a slave and wait
// in RD_WAIT for iRD_EN or a timeout.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   iADDR, iWE, iRE    host request (one-cycle pulses), iDATA write data
//   oBUSY              read in flight, through its completion cycle
//   oRD_EN, oRD        read-complete pulse and held read data
//   oERR, oERR_CODE    one-cycle error pulse and sticky cause
//   oWE_BIT, oRE_BIT   one-hot slave strobes, oWD held write data
//   iRD_EN, iRD        slave read valid and data
module reg_bus_bridge
  import reg_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = {DATA_WIDTH{ERR_DATA_FILL}}
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] iADDR,
  input  logic                  iWE,
  input  logic                  iRE,
  input  logic [DATA_WIDTH-1:0] iDATA,
  output logic                  oBUSY,
  output logic                  oRD_EN,
  output logic [DATA_WIDTH-1:0] oRD,
  output logic                  oERR,
  output logic [1:0]            oERR_CODE,
  output logic [NUM_SLAVES-1:0] oWE_BIT,
  output logic [NUM_SLAVES-1:0] oRE_BIT,
  output logic [DATA_WIDTH-1:0] oWD,
  input  logic                  iRD_EN,
  input  logic [DATA_WIDTH-1:0] iRD
);

  // One extra bit so the compare covers the full address width even when
  // NUM_SLAVES equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] NUM_SLAVES_W = (ADDR_WIDTH + 1)'(NUM_SLAVES);

  state_t                state_reg, state_next;
  logic [NUM_SLAVES-1:0] we_bit_reg, we_bit_next;
  logic [NUM_SLAVES-1:0] re_bit_reg, re_bit_next;
  logic [DATA_WIDTH-1:0] wd_reg, wd_next;
  logic [DATA_WIDTH-1:0] rd_reg, rd_next;
  logic                  rd_en_reg, rd_en_next;
  logic                  err_reg, err_next;
  logic [1:0]            err_code_reg, err_code_next;
  // Marks the completion cycle of an in-flight read so oBUSY covers it.
  logic                  done_reg, done_next;

  logic [NUM_SLAVES-1:0] addr_sel;
  logic                  in_range;
  logic                  timer_load;
  logic                  timer_en;
  logic                  timer_expire;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign addr_sel[gi] = (iADDR == ADDR_WIDTH'(gi));
    end
  endgenerate

  assign in_range = ({1'b0, iADDR} < NUM_SLAVES_W);
  assign timer_en = (state_reg == ST_RD_WAIT);

  reg_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .iLOAD   (timer_load),
    .iEN     (timer_en),
    .oEXPIRE (timer_expire)
  );

  always_comb begin
    state_next    = state_reg;
    we_bit_next   = '0;
    re_bit_next   = '0;
    wd_next       = wd_reg;
    rd_next       = rd_reg;
    rd_en_next    = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    done_next     = 1'b0;
    timer_load    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (iWE || iRE) begin
          // done_reg: the previous read is still in its completion cycle.
          if (done_reg || (iWE && iRE)) begin
            err_next      = 1'b1;
            err_code_next = ERR_PROTO;
          end else if (!in_range) begin
            err_next      = 1'b1;
            err_code_next = ERR_RANGE;
            if (iRE) begin
              rd_next    = ERR_DATA;
              rd_en_next = 1'b1;
            end
          end else if (iWE) begin
            we_bit_next = addr_sel;
            wd_next     = iDATA;
          end else begin
            re_bit_next = addr_sel;
            timer_load  = 1'b1;
            state_next  = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        if (iWE || iRE) begin
          err_next      = 1'b1;
          err_code_next = ERR_PROTO;
        end
        // A slave answer in the expiry cycle still counts as a good read.
        if (iRD_EN) begin
          rd_next    = iRD;
          rd_en_next = 1'b1;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (timer_expire) begin
          rd_next       = ERR_DATA;
          rd_en_next    = 1'b1;
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          done_next     = 1'b1;
          state_next    = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      we_bit_reg   <= '0;
      re_bit_reg   <= '0;
      wd_reg       <= '0;
      rd_reg       <= '0;
      rd_en_reg    <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      we_bit_reg   <= we_bit_next;
      re_bit_reg   <= re_bit_next;
      wd_reg       <= wd_next;
      rd_reg       <= rd_next;
      rd_en_reg    <= rd_en_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      done_reg     <= done_next;
    end
  end

  assign oBUSY     = (state_reg == ST_RD_WAIT) || done_reg;
  assign oRD_EN    = rd_en_reg;
  assign oRD       = rd_reg;
  assign oERR      = err_reg;
  assign oERR_CODE = err_code_reg;
  assign oWE_BIT   = we_bit_reg;
  assign oRE_BIT   = re_bit_reg;
  assign oWD       = wd_reg;

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Bench for reg_bus_bridge. Three instances share clock, reset, address and
// slave-response signals; each gets its own iWE/iRE so only the instance
// under test sees a request:
//   A: defaults (8-bit data, 8 slaves, TIMEOUT 255)
//   B: TIMEOUT 4
//   C: 32-bit data, 20 slaves
module tb_reg_bus_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] addr;
  logic [2:0]  we_v, re_v;
  logic [31:0] data;
  logic        rd_en_in;
  logic [31:0] rd_in;

  logic       a_busy, a_rd_en, a_err;
  logic [7:0] a_rd, a_wd, a_we, a_re;
  logic [1:0] a_code;
  logic       b_busy, b_rd_en, b_err;
  logic [7:0] b_rd, b_wd, b_we, b_re;
  logic [1:0] b_code;
  logic        c_busy, c_rd_en, c_err;
  logic [31:0] c_rd, c_wd;
  logic [19:0] c_we, c_re;
  logic [1:0]  c_code;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  reg_bus_bridge u_a (
    .CLK(CLK), .RST(RST), .iADDR(addr), .iWE(we_v[0]), .iRE(re_v[0]),
    .iDATA(data[7:0]), .oBUSY(a_busy), .oRD_EN(a_rd_en), .oRD(a_rd),
    .oERR(a_err), .oERR_CODE(a_code), .oWE_BIT(a_we), .oRE_BIT(a_re),
    .oWD(a_wd), .iRD_EN(rd_en_in), .iRD(rd_in[7:0])
  );

  reg_bus_bridge #(.TIMEOUT(4)) u_b (
    .CLK(CLK), .RST(RST), .iADDR(addr), .iWE(we_v[1]), .iRE(re_v[1]),
    .iDATA(data[7:0]), .oBUSY(b_busy), .oRD_EN(b_rd_en), .oRD(b_rd),
    .oERR(b_err), .oERR_CODE(b_code), .oWE_BIT(b_we), .oRE_BIT(b_re),
    .oWD(b_wd), .iRD_EN(rd_en_in), .iRD(rd_in[7:0])
  );

  reg_bus_bridge #(.DATA_WIDTH(32), .NUM_SLAVES(20)) u_c (
    .CLK(CLK), .RST(RST), .iADDR(addr), .iWE(we_v[2]), .iRE(re_v[2]),
    .iDATA(data), .oBUSY(c_busy), .oRD_EN(c_rd_en), .oRD(c_rd),
    .oERR(c_err), .oERR_CODE(c_code), .oWE_BIT(c_we), .oRE_BIT(c_re),
    .oWD(c_wd), .iRD_EN(rd_en_in), .iRD(rd_in)
  );

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        we;
    logic        re;
    logic [7:0]  data;
    logic [7:0]  e_we;
    logic [7:0]  e_re;
    logic [7:0]  e_wd;
    logic [7:0]  e_rd;
    logic        e_rd_en;
    logic        e_err;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    we_v = '0;
    re_v = '0;
  endtask

  initial begin
    RST = 1'b1; addr = '0; we_v = '0; re_v = '0; data = '0;
    rd_en_in = 1'b0; rd_in = '0;

    //                name          addr     we    re    data   e_we   e_re   e_wd   e_rd   rd_en err   code
    vecs[0] = '{"wr3_a5",     16'h0003, 1'b1, 1'b0, 8'hA5, 8'h08, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{"wr0_5a",     16'h0000, 1'b1, 1'b0, 8'h5A, 8'h01, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{"wr7_3c",     16'h0007, 1'b1, 1'b0, 8'h3C, 8'h80, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[3] = '{"wr8_oor",    16'h0008, 1'b1, 1'b0, 8'h11, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b1, 2'd1};
    vecs[4] = '{"wr103_oor",  16'h0103, 1'b1, 1'b0, 8'h22, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b1, 2'd1};
    vecs[5] = '{"rd100_oor",  16'h0100, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hFF, 1'b1, 1'b1, 2'd1};
    vecs[6] = '{"we_re_both", 16'h0001, 1'b1, 1'b1, 8'h77, 8'h00, 8'h00, 8'h3C, 8'hFF, 1'b0, 1'b1, 2'd3};
    vecs[7] = '{"wr1_77",     16'h0001, 1'b1, 1'b0, 8'h77, 8'h02, 8'h00, 8'h77, 8'hFF, 1'b0, 1'b0, 2'd3};

    // Reset state
    repeat (2) tick();
    chk("rst_a_outs", {a_busy, a_rd_en, a_err, a_code, a_rd, a_wd, a_we, a_re}, 32'h0);
    chk("rst_b_outs", {b_busy, b_rd_en, b_err, b_code, b_rd, b_wd}, 32'h0);
    chk("rst_c_rd", c_rd, 32'h0);
    chk("rst_c_wd", c_wd, 32'h0);
    RST = 1'b0;
    tick();

    // Single-cycle transactions on A
    for (int i = 0; i < 8; i++) begin
      addr = vecs[i].addr; data = {24'h0, vecs[i].data};
      we_v[0] = vecs[i].we; re_v[0] = vecs[i].re;
      tick();
      clear_req();
      chk({vecs[i].name, "_we_bit"}, a_we, vecs[i].e_we);
      chk({vecs[i].name, "_re_bit"}, a_re, vecs[i].e_re);
      chk({vecs[i].name, "_wd"}, a_wd, vecs[i].e_wd);
      chk({vecs[i].name, "_rd"}, a_rd, vecs[i].e_rd);
      chk({vecs[i].name, "_rd_en"}, a_rd_en, vecs[i].e_rd_en);
      chk({vecs[i].name, "_err"}, a_err, vecs[i].e_err);
      chk({vecs[i].name, "_code"}, a_code, vecs[i].e_code);
      chk({vecs[i].name, "_busy"}, a_busy, 1'b0);
      tick();
      chk({vecs[i].name, "_pulse_end"}, {a_we, a_re, a_rd_en, a_err}, 32'h0);
    end

    // Back-to-back writes: 2 then 4 in consecutive cycles
    addr = 16'd2; data = 32'h12; we_v[0] = 1'b1;
    tick();
    addr = 16'd4; data = 32'h34;
    chk("b2b_first_we", a_we, 8'h04);
    chk("b2b_first_wd", a_wd, 8'h12);
    tick();
    clear_req();
    chk("b2b_second_we", a_we, 8'h10);
    chk("b2b_second_wd", a_wd, 8'h34);
    chk("b2b_err", a_err, 1'b0);
    tick();

    // Read 5, slave answers 4 cycles after the strobe
    addr = 16'd5; re_v[0] = 1'b1;
    tick();                                   // T+1
    clear_req();
    chk("rd5_re_bit", a_re, 8'h20);
    chk("rd5_busy_t1", a_busy, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      tick();                                 // T+2..T+4
      chk("rd5_wait_busy", a_busy, 1'b1);
      chk("rd5_wait_quiet", {a_re, a_rd_en}, 32'h0);
    end
    tick();                                   // T+5
    chk("rd5_busy_t5", a_busy, 1'b1);
    rd_en_in = 1'b1; rd_in = 32'h3C;
    tick();                                   // T+6
    rd_en_in = 1'b0; rd_in = 32'h0;
    chk("rd5_rd_en", a_rd_en, 1'b1);
    chk("rd5_rd", a_rd, 8'h3C);
    chk("rd5_busy_done", a_busy, 1'b1);
    chk("rd5_err", a_err, 1'b0);
    tick();                                   // T+7: new read allowed
    chk("rd5_after_rd_en", a_rd_en, 1'b0);
    chk("rd5_after_busy", a_busy, 1'b0);
    chk("rd5_rd_held", a_rd, 8'h3C);

    // Read 6 issued right after completion, then a write during RD_WAIT
    addr = 16'd6; re_v[0] = 1'b1;
    tick();
    clear_req();
    chk("rd6_re_bit", a_re, 8'h40);
    chk("rd6_err", a_err, 1'b0);
    addr = 16'd1; data = 32'h99; we_v[0] = 1'b1;
    tick();
    clear_req();
    chk("proto_err", a_err, 1'b1);
    chk("proto_code", a_code, 2'd3);
    chk("proto_we_bit", a_we, 8'h00);
    chk("proto_wd", a_wd, 8'h34);
    chk("proto_busy", a_busy, 1'b1);
    rd_en_in = 1'b1; rd_in = 32'h81;
    tick();
    rd_en_in = 1'b0;
    chk("proto_rd_en", a_rd_en, 1'b1);
    chk("proto_rd", a_rd, 8'h81);
    chk("proto_rd_err", a_err, 1'b0);
    tick();

    // Timeout on B (TIMEOUT=4)
    addr = 16'd2; re_v[1] = 1'b1;
    tick();                                   // T+1
    clear_req();
    chk("to_re_bit", b_re, 8'h04);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("to_wait_rd_en", b_rd_en, 1'b0);
      chk("to_wait_busy", b_busy, 1'b1);
    end
    tick();                                   // T+5
    chk("to_rd_en", b_rd_en, 1'b1);
    chk("to_rd", b_rd, 8'hFF);
    chk("to_err", b_err, 1'b1);
    chk("to_code", b_code, 2'd2);
    tick();
    chk("to_pulse_end", {b_rd_en, b_err, b_busy}, 32'h0);

    // iRD_EN in the expiry cycle wins
    addr = 16'd3; re_v[1] = 1'b1;
    tick();                                   // T+1
    clear_req();
    repeat (3) tick();                        // T+4
    rd_en_in = 1'b1; rd_in = 32'h6D;
    tick();                                   // T+5
    rd_en_in = 1'b0;
    chk("race_rd_en", b_rd_en, 1'b1);
    chk("race_rd", b_rd, 8'h6D);
    chk("race_err", b_err, 1'b0);
    chk("race_code", b_code, 2'd2);
    tick();

    // Reset during RD_WAIT on A, then a stray iRD_EN
    addr = 16'd0; re_v[0] = 1'b1;
    tick();
    clear_req();
    chk("rstw_busy", a_busy, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstw_outs", {a_busy, a_rd_en, a_err, a_code, a_rd, a_wd, a_we, a_re}, 32'h0);
    rd_en_in = 1'b1; rd_in = 32'h55;
    tick();
    rd_en_in = 1'b0;
    chk("rstw_stray_rd_en", a_rd_en, 1'b0);
    chk("rstw_stray_rd", a_rd, 8'h00);
    chk("rstw_stray_err", a_err, 1'b0);
    tick();

    // Wide instance C: read 19 with minimum latency
    addr = 16'd19; re_v[2] = 1'b1;
    tick();                                   // T+1
    clear_req();
    chk("c_rd19_re_bit", c_re, 20'h80000);
    rd_en_in = 1'b1; rd_in = 32'hDEADBEEF;
    tick();                                   // T+2
    rd_en_in = 1'b0;
    chk("c_rd19_rd_en", c_rd_en, 1'b1);
    chk("c_rd19_rd", c_rd, 32'hDEADBEEF);
    chk("c_rd19_err", c_err, 1'b0);
    tick();
    addr = 16'd19; data = 32'h12345678; we_v[2] = 1'b1;
    tick();
    clear_req();
    chk("c_wr19_we_bit", c_we, 20'h80000);
    chk("c_wr19_wd", c_wd, 32'h12345678);
    addr = 16'd20; data = 32'hCAFEF00D; we_v[2] = 1'b1;
    tick();
    clear_req();
    chk("c_wr20_we_bit", c_we, 20'h0);
    chk("c_wr20_wd", c_wd, 32'h12345678);
    chk("c_wr20_err", c_err, 1'b1);
    chk("c_wr20_code", c_code, 2'd1);
    addr = 16'd20; re_v[2] = 1'b1;
    tick();
    clear_req();
    chk("c_rd20_rd", c_rd, 32'hFFFFFFFF);
    chk("c_rd20_rd_en", c_rd_en, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
